// File: rtl/fp_pkg.sv
// Shared definitions for the sequential floating-point divider: FSM encoding,
// binary32 constants and a zero-detect helper.
`timescale 1ns/1ps
package fp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        NORM = 2'd2
    } div_state_e;

    localparam logic [7:0] FP_BIAS   = 8'd127;
    localparam int         DIV_ITER  = 25;
    localparam logic [7:0] EXP_INF   = 8'hFF;
    localparam logic [4:0] LAST_ITER = 5'(DIV_ITER - 1);

    // Magnitude bits only: both +0 and -0 count as zero.
    function automatic logic is_zero(input logic [30:0] mag);
        return (mag == 31'd0);
    endfunction

endpackage

// File: rtl/normalize_div.sv
// Combinational normalize stage for the divider: picks the fraction window
// from the 25-bit quotient and adjusts the exponent when q lies below 1.0.
`timescale 1ns/1ps
module normalize_div (
    input  logic [24:0] q,
    input  logic [7:0]  Etmp,
    output logic [22:0] Fraction,
    output logic [7:0]  Exponent
);

    // Quotient is in (0.5, 2): either the integer bit is set or the next one is.
    always_comb begin
        Fraction = 23'd0;
        Exponent = 8'd0;
        if (q[24]) begin
            Fraction = q[23:1];
            Exponent = Etmp;
        end else begin
            Fraction = q[22:0];
            Exponent = Etmp - 8'd1;
        end
    end

endmodule

// File: rtl/divide_fp.sv
// Sequential binary32 divider: 25-step restoring division of the significands
// followed by one normalize cycle; truncating, wrapping 8-bit exponent.
`timescale 1ns/1ps
module divide_fp
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] InA,
    input  logic [31:0] InB,
    output logic        out_valid,
    output logic [31:0] Out,
    output logic        div_by_zero
);

    div_state_e  r_state;
    div_state_e  w_state_next;
    logic [4:0]  r_cnt;
    logic        r_sign;
    logic [7:0]  r_etmp;
    logic [23:0] r_mb;
    logic [24:0] r_rem;
    logic [24:0] r_q;
    logic        r_za;
    logic        r_zb;
    logic [31:0] r_out;
    logic        r_dbz;
    logic        r_out_valid;
    logic        r_in_ready;

    logic        w_ge;
    logic [24:0] w_diff;
    logic [24:0] w_rem_next;
    logic [24:0] w_q_next;
    logic [22:0] w_frac;
    logic [7:0]  w_exp;
    logic [31:0] w_out_next;
    logic        w_dbz_next;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = CALC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            CALC: begin
                if (r_cnt == LAST_ITER) begin
                    w_state_next = NORM;
                end else begin
                    w_state_next = CALC;
                end
            end
            NORM:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // One restoring step; the remainder stays below 2*MB so 25 bits suffice.
    always_comb begin
        w_ge       = (r_rem >= {1'b0, r_mb});
        w_diff     = r_rem;
        w_q_next   = {r_q[23:0], 1'b0};
        if (w_ge) begin
            w_diff   = r_rem - {1'b0, r_mb};
            w_q_next = {r_q[23:0], 1'b1};
        end else begin
            w_diff   = r_rem;
            w_q_next = {r_q[23:0], 1'b0};
        end
        w_rem_next = w_diff << 1;
    end

    normalize_div u_normalize (
        .q        (r_q),
        .Etmp     (r_etmp),
        .Fraction (w_frac),
        .Exponent (w_exp)
    );

    // Special-case mux: a zero divisor wins over a zero dividend.
    always_comb begin
        w_out_next = {r_sign, w_exp, w_frac};
        w_dbz_next = 1'b0;
        if (r_zb) begin
            w_out_next = {r_sign, EXP_INF, 23'd0};
            w_dbz_next = 1'b1;
        end else if (r_za) begin
            w_out_next = 32'd0;
            w_dbz_next = 1'b0;
        end else begin
            w_out_next = {r_sign, w_exp, w_frac};
            w_dbz_next = 1'b0;
        end
    end

    // Operand capture, iteration datapath and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 5'd0;
            r_sign      <= 1'b0;
            r_etmp      <= 8'd0;
            r_mb        <= 24'd0;
            r_rem       <= 25'd0;
            r_q         <= 25'd0;
            r_za        <= 1'b0;
            r_zb        <= 1'b0;
            r_out       <= 32'd0;
            r_dbz       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            r_out_valid <= (r_state == NORM);
            r_in_ready  <= (w_state_next == IDLE);
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign <= InA[31] ^ InB[31];
                        r_etmp <= InA[30:23] - InB[30:23] + FP_BIAS;
                        r_mb   <= {1'b1, InB[22:0]};
                        r_rem  <= {2'b01, InA[22:0]};
                        r_q    <= 25'd0;
                        r_za   <= is_zero(InA[30:0]);
                        r_zb   <= is_zero(InB[30:0]);
                        r_cnt  <= 5'd0;
                    end else begin
                        r_cnt  <= 5'd0;
                    end
                end
                CALC: begin
                    r_rem <= w_rem_next;
                    r_q   <= w_q_next;
                    if (r_cnt == LAST_ITER) begin
                        r_cnt <= 5'd0;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                NORM: begin
                    r_out <= w_out_next;
                    r_dbz <= w_dbz_next;
                end
                default: begin
                    r_cnt <= 5'd0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign Out         = r_out;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_divide_fp.sv
// Bench for divide_fp: vector table plus handshake, back-to-back and
// mid-operation reset sequences, with a queue-based scoreboard on every result.
`timescale 1ns/1ps
module tb_divide_fp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] InA = 32'd0;
    logic [31:0] InB = 32'd0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] Out;
    logic        div_by_zero;

    always #5 clk = ~clk;

    divide_fp dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .InA         (InA),
        .InB         (InB),
        .out_valid   (out_valid),
        .Out         (Out),
        .div_by_zero (div_by_zero)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int last_ov = 0;
    int n_b2b = 0;
    bit b2b = 1'b0;

    typedef struct {
        logic [32:0] res;
        int          acc;
    } sb_t;
    sb_t sb[$];
    sb_t e_pop;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] out;
        logic        dbz;
        string       name;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: long division of MA*2^24 by MB, then the same format rules.
    function automatic logic [32:0] fp_div_model(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] num;
        logic [47:0] q48;
        logic [24:0] q;
        logic [7:0]  e;
        logic        s;
        s = a[31] ^ b[31];
        if (b[30:0] == 31'd0) return {1'b1, s, 8'hFF, 23'd0};
        if (a[30:0] == 31'd0) return {1'b0, 32'd0};
        num = {1'b1, a[22:0], 24'd0};
        q48 = num / {24'd0, 1'b1, b[22:0]};
        q   = q48[24:0];
        e   = a[30:23] - b[30:23] + 8'd127;
        if (q[24]) return {1'b0, s, e, q[23:1]};
        e = e - 8'd1;
        return {1'b0, s, e, q[22:0]};
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Scoreboard: push on every accept, pop and compare on every out_valid.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                sb.push_back('{res: fp_div_model(InA, InB), acc: edge_cnt + 1});
            end
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid actual=1 required=0 at edge %0d", edge_cnt);
                end else begin
                    e_pop = sb.pop_front();
                    check("sb_out", Out, e_pop.res[31:0]);
                    check("sb_dbz", {31'd0, div_by_zero}, {31'd0, e_pop.res[32]});
                    check("sb_latency", edge_cnt - e_pop.acc, 32'd26);
                end
                if (b2b) begin
                    n_b2b++;
                    if (last_ov != 0) check("b2b_period", edge_cnt - last_ov, 32'd27);
                    last_ov = edge_cnt;
                end
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #2;
            if (in_ready) return;
        end
        checks++;
        errors++;
        $display("FAIL idle_timeout actual=in_ready=0 required=1");
    endtask

    task automatic wait_result(output logic [31:0] o, output logic d, output bit got);
        got = 1'b0;
        o = 32'd0;
        d = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                o = Out;
                d = div_by_zero;
                got = 1'b1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL result_timeout actual=no_out_valid required=out_valid");
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_o,
                          input logic exp_d, input string name);
        logic [31:0] o;
        logic        d;
        bit          got;
        wait_idle();
        in_valid = 1'b1;
        InA = a;
        InB = b;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        InA = $urandom;
        InB = $urandom;
        wait_result(o, d, got);
        if (got) begin
            check({name, "_out"}, o, exp_o);
            check({name, "_dbz"}, {31'd0, d}, {31'd0, exp_d});
        end
    endtask

    initial begin
        logic [31:0] o;
        logic        d;
        bit          got;

        vecs[0] = '{32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, "six_div_two"};
        vecs[1] = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, "one_div_three"};
        vecs[2] = '{32'hBFC00000, 32'h3F000000, 32'hC0400000, 1'b0, "neg_sign"};
        vecs[3] = '{32'h00000000, 32'h40A00000, 32'h00000000, 1'b0, "zero_div_five"};
        vecs[4] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, "div_pos_zero"};
        vecs[5] = '{32'h3F800000, 32'h80000000, 32'hFF800000, 1'b1, "div_neg_zero"};

        #12;
        check("rst_out", Out, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].out, vecs[i].dbz, vecs[i].name);
        end

        // in_valid pulses while busy must not start a new operation.
        wait_idle();
        in_valid = 1'b1;
        InA = 32'h40C00000;
        InB = 32'h40000000;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            repeat (2) @(posedge clk);
            #2;
            in_valid = 1'b1;
            InA = $urandom;
            InB = $urandom;
            @(posedge clk);
            #2;
            in_valid = 1'b0;
        end
        wait_result(o, d, got);
        if (got) check("busy_ignored_out", o, 32'h40400000);

        // in_valid held high with operands changing every cycle.
        wait_idle();
        b2b = 1'b1;
        last_ov = 0;
        n_b2b = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 82; c++) begin
            InA = $urandom;
            InB = $urandom;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        repeat (35) @(posedge clk);
        #2;
        b2b = 1'b0;
        check("b2b_results", n_b2b, 32'd4);
        check("sb_drained", sb.size(), 32'd0);

        // Asynchronous reset in the middle of CALC aborts the operation.
        wait_idle();
        in_valid = 1'b1;
        InA = 32'h3F800000;
        InB = 32'h40400000;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_out", Out, 32'd0);
        check("abort_dbz", {31'd0, div_by_zero}, 32'd0);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run_op(32'h40000000, 32'h40000000, 32'h3F800000, 1'b0, "two_div_two");

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
